// File: rtl/descrambler_if.sv
// Handshake bundle for the descrambler: data in, seed in, data out.
// Master drives offers and reads; slave is the descrambler itself.
interface descrambler_if;
  logic [3:0] in_data;
  logic       in_en;
  logic       in_rdy;
  logic [3:0] seed_data;
  logic       seed_en;
  logic       seed_rdy;
  logic       out_en;
  logic [3:0] out_data;
  logic       out_rdy;

  modport master (
    output in_data,
    output in_en,
    input  in_rdy,
    output seed_data,
    output seed_en,
    input  seed_rdy,
    output out_en,
    input  out_data,
    input  out_rdy
  );

  modport slave (
    input  in_data,
    input  in_en,
    output in_rdy,
    input  seed_data,
    input  seed_en,
    output seed_rdy,
    input  out_en,
    output out_data,
    output out_rdy
  );
endinterface

// File: rtl/descrambler.sv
// Additive LFSR (x^4+x^3+1) descrambler on 4-bit words with a
// show-ahead output FIFO decoupling the consumer from the input stream.
module descrambler #(
  parameter int DEPTH = 4
) (
  input logic          CLK,
  input logic          RST_N,
  descrambler_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   FULL = DEPTH[AW:0];
  localparam logic [AW:0]   C1   = 1;
  localparam logic [AW-1:0] P1   = 1;

  typedef enum logic {
    WAIT_SEED = 1'b0,
    RUN       = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nx;

  logic [3:0]    r_s;
  logic [3:0]    w_s_nx;
  logic [AW:0]   r_count;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [3:0]    r_mem [DEPTH];
  logic          r_seed_rdy;

  logic w_in_rdy;
  logic w_out_rdy;
  logic w_wr;
  logic w_rd;
  logic w_seed;

  // Four serial steps; the key word used before them is the state itself.
  function automatic logic [3:0] lfsr4(input logic [3:0] s);
    logic [3:0] t;
    t = s;
    for (int k = 0; k < 4; k++) begin
      t = {t[2:0], t[3] ^ t[2]};
    end
    return t;
  endfunction

  assign w_seed = bus.seed_en & r_seed_rdy;
  assign w_wr   = bus.in_en & w_in_rdy;
  assign w_rd   = bus.out_en & w_out_rdy;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= WAIT_SEED;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (1'b1)
      w_seed:  w_state_nx = RUN;
      default: w_state_nx = r_state;
    endcase
  end

  always_comb begin
    w_in_rdy  = 1'b0;
    w_out_rdy = 1'b0;
    w_in_rdy  = (r_state == RUN) &&
                (r_count < FULL) &&
                !bus.seed_en;
    w_out_rdy = (r_count != '0);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_seed_rdy <= 1'b0;
    end else begin
      r_seed_rdy <= 1'b1;
    end
  end

  // An all-zero seed would lock the LFSR, so it is replaced by 0001.
  always_comb begin
    w_s_nx = r_s;
    unique case (1'b1)
      w_seed: begin
        w_s_nx = (bus.seed_data == 4'b0000) ?
                 4'b0001 : bus.seed_data;
      end
      w_wr:    w_s_nx = lfsr4(r_s);
      default: w_s_nx = r_s;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_s <= 4'b0001;
    end else begin
      r_s <= w_s_nx;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 4'b0000;
      end
    end else if (w_wr) begin
      r_mem[r_wptr] <= bus.in_data ^ r_s;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + P1;
      if (w_rd) r_rptr <= r_rptr + P1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_count <= '0;
    end else begin
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + C1;
        2'b01:   r_count <= r_count - C1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.in_rdy   = w_in_rdy;
  assign bus.seed_rdy = r_seed_rdy;
  assign bus.out_rdy  = w_out_rdy;
  assign bus.out_data = w_out_rdy ? r_mem[r_rptr] : 4'b0000;

endmodule
